mac_engine: RTL

MAC_ENGINE -- requirements
Module: mac_engine

---
 rtl/mac_engine.sv | 136 +++++++++++++
 1 files changed

// File: rtl/mac_engine.sv
// Multiply-accumulate engine: sums N_TERMS unsigned a*b products into one registered result.
// Optional macro MAC_ENGINE_SAT_EN clamps the accumulator on overflow instead of wrapping.
module mac_engine #(
  parameter int DATA_W  = 4,
  parameter int ACC_W   = 12,
  parameter int N_TERMS = 4
) (
  input  logic                               clk_out,
  input  logic                               rst,
  input  logic                               start,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [DATA_W-1:0]                  a,
  input  logic [DATA_W-1:0]                  b,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [ACC_W-1:0]                   out,
  output logic                               ovf,
  output logic                               busy,
  output logic [$clog2(N_TERMS+1)-1:0]       term_cnt,
  output logic [1:0]                         dbg_state
);

  localparam int CNT_W = $clog2(N_TERMS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(N_TERMS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Handshakes: an operand pair transfers on a rising edge where in_valid && in_ready;
  // the result is consumed on a rising edge where out_valid && out_ready.
  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [ACC_W-1:0]        prod_q, prod_d;
  logic                    pvld_q, pvld_d;
  logic [ACC_W-1:0]        acc_q, acc_d;
  logic                    ovf_q, ovf_d;
  logic [ACC_W-1:0]        out_q, out_d;

  logic                    accept;
  logic                    xfer;
  logic [2*DATA_W-1:0]     prod_full;
  logic [ACC_W:0]          sum_full;

  assign accept    = (state_q == ACCUM) && (cnt_q < CNT_MAX);
  assign xfer      = in_valid && accept;
  assign prod_full = (2*DATA_W)'(a) * (2*DATA_W)'(b);
  assign sum_full  = {1'b0, acc_q} + {1'b0, prod_q};

  always_ff @(posedge clk_out) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      prod_q  <= '0;
      pvld_q  <= 1'b0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      pvld_q  <= pvld_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      out_q   <= out_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    pvld_d  = 1'b0;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    out_d   = out_q;

    // The product loaded last cycle lands in the accumulator this cycle.
    if (pvld_q) begin
      if (sum_full[ACC_W]) begin
        ovf_d = 1'b1;
`ifdef MAC_ENGINE_SAT_EN
        acc_d = '1;
`else
        acc_d = sum_full[ACC_W-1:0];
`endif
      end else begin
        acc_d = sum_full[ACC_W-1:0];
      end
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (xfer) begin
          prod_d = ACC_W'(prod_full);
          pvld_d = 1'b1;
          cnt_d  = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_MAX - CNT_W'(1)) state_d = DRAIN;
        end
      end
      // Wait one cycle for the final product to be summed before publishing.
      DRAIN: begin
        if (!pvld_q) begin
          out_d   = acc_q;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = !rst && accept;
  assign out_valid = !rst && (state_q == DONE);
  assign busy      = !rst && (state_q != IDLE);
  assign out       = out_q;
  assign ovf       = ovf_q;
  assign term_cnt  = cnt_q;
  assign dbg_state = state_q;

endmodule
